// File: rtl/param_frame_mapper_pkg.sv
// Shared FSM states, word-type codes and CRC step for the frame mapper.
// The CRC step is written width-generic up to 16 bits.
package param_frame_mapper_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FAS  = 2'd1;
  localparam logic [1:0] S_PYLD = 2'd2;
  localparam logic [1:0] S_CRC  = 2'd3;

  localparam logic [1:0] WT_FAS  = 2'd0;
  localparam logic [1:0] WT_PYLD = 2'd1;
  localparam logic [1:0] WT_FILL = 2'd2;
  localparam logic [1:0] WT_CRC  = 2'd3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One whole word shifted in MSB-first; w is the live width.
  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [15:0] d,
    input logic [15:0] poly,
    input int          w
  );
    logic [15:0] v;
    logic        fb;
    v = c;
    for (int i = 15; i >= 0; i--) begin
      if (i < w) begin
        fb = v[w-1] ^ d[i];
        v  = (v << 1) ^ (fb ? poly : 16'h0);
      end
    end
    return v & ((16'h1 << w) - 16'h1);
  endfunction

endpackage

// File: rtl/param_crc_gen.sv
// Word-wide CRC register with seed and advance controls.
// Seed wins over advance when both are raised.
module param_crc_gen
  import param_frame_mapper_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = 'h07,
  parameter logic [W-1:0] INIT = '0
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_seed,
  input  logic         i_adv,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_crc
);

  logic [W-1:0] r_crc;
  logic [W-1:0] w_nxt;
  logic [15:0]  w_step;

  always_comb begin
    w_step = crc_step(16'(r_crc), 16'(i_data),
                      16'(POLY), W);
    w_nxt  = w_step[W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= INIT;
    end else if (i_seed) begin
      r_crc <= INIT;
    end else if (i_adv) begin
      r_crc <= w_nxt;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/param_frame_mapper.sv
// Sender-side mapper: FAS header, payload or fill, trailing CRC word,
// built into ROWS x COLS frames behind a single output register.
module param_frame_mapper
  import param_frame_mapper_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ROWS        = 4,
  parameter int                COLS        = 1088,
  parameter int                FAS_LEN     = 2,
  parameter logic [31:0]       FAS_PATTERN = 32'hF628_F628,
  parameter bit                FILL_MODE   = 1'b0,
  parameter logic [DATA_W-1:0] FILL_WORD   = '0,
  parameter logic [DATA_W-1:0] CRC_POLY    = 'h07,
  parameter logic [DATA_W-1:0] CRC_INIT    = '0,
  localparam int               RW          = cnt_w(ROWS),
  localparam int               CW          = cnt_w(COLS)
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_pyld_data,
  input  logic              i_pyld_data_valid,
  output logic              o_pyld_data_req,
  output logic [DATA_W-1:0] o_frame_data,
  output logic              o_frame_data_valid,
  output logic              o_frame_data_fas,
  output logic              o_fill_ins,
  input  logic              i_line_fifo_ready,
  input  logic              i_tran_rec_fifo_ready,
  input  logic              i_line_retrans_req,
  input  logic              i_corrupt_en,
  output logic              o_crc_val,
  output logic [RW-1:0]     o_row_cnt,
  output logic [CW-1:0]     o_col_cnt
);

  localparam int            FLEN    = ROWS * COLS;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_word;
  logic              r_valid;
  logic [1:0]        r_wtype;
  logic [1:0]        w_wtype;
  logic              w_out_rdy;
  logic              w_slot;
  logic              w_req;
  logic              w_xfer;
  logic              w_load;
  logic              w_seed;
  logic              w_adv;
  int                w_pos;
  logic [31:0]       w_fas_sh;
  logic [DATA_W-1:0] w_crc;

  always_comb begin
    w_out_rdy = i_line_fifo_ready & i_tran_rec_fifo_ready;
    w_slot    = !r_valid | w_out_rdy;
    w_pos     = int'(r_row) * COLS + int'(r_col);
    w_fas_sh  = FAS_PATTERN << (w_pos * DATA_W);
    w_req     = (r_state == S_PYLD) & w_slot
              & !i_line_retrans_req;
    w_xfer    = w_req & i_pyld_data_valid;
  end

  always_comb begin
    w_load      = 1'b0;
    w_word      = r_data;
    w_wtype     = r_wtype;
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_seed      = 1'b0;
    if (i_line_retrans_req) begin
      w_seed      = 1'b1;
      w_state_nxt = i_en ? S_FAS : S_IDLE;
    end else begin
      unique case (1'b1)
        r_state == S_IDLE: begin
          if (i_en) w_state_nxt = S_FAS;
        end
        r_state == S_FAS: begin
          w_load  = w_slot;
          w_word  = w_fas_sh[31 -: DATA_W];
          w_wtype = WT_FAS;
          if (w_slot && w_pos == FAS_LEN - 1)
            w_state_nxt = S_PYLD;
        end
        r_state == S_PYLD: begin
          if (w_xfer) begin
            w_load  = 1'b1;
            w_word  = i_pyld_data;
            w_wtype = WT_PYLD;
          end else if (FILL_MODE && w_slot
                       && !i_pyld_data_valid) begin
            w_load  = 1'b1;
            w_word  = FILL_WORD;
            w_wtype = WT_FILL;
          end
          w_adv = w_load;
          if (w_load && w_pos == FLEN - 2)
            w_state_nxt = S_CRC;
        end
        default: begin
          w_load  = w_slot;
          w_word  = w_crc
                  ^ {{(DATA_W-1){1'b0}}, i_corrupt_en};
          w_wtype = WT_CRC;
          if (w_slot) begin
            w_seed      = 1'b1;
            w_state_nxt = i_en ? S_FAS : S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wtype <= WT_PYLD;
    end else begin
      r_state <= w_state_nxt;
      if (i_line_retrans_req) begin
        r_row   <= '0;
        r_col   <= '0;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_data  <= w_word;
        r_wtype <= w_wtype;
        r_valid <= 1'b1;
        if (r_col == COL_MAX) begin
          r_col <= '0;
          r_row <= (r_row == ROW_MAX) ? '0
                 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (w_out_rdy) begin
        r_valid <= 1'b0;
      end
    end
  end

  param_crc_gen #(
    .W    (DATA_W),
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_seed  (w_seed),
    .i_adv   (w_adv),
    .i_data  (w_word),
    .o_crc   (w_crc)
  );

  assign o_pyld_data_req    = w_req;
  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_valid & (r_wtype == WT_FAS);
  assign o_fill_ins         = r_valid & (r_wtype == WT_FILL);
  assign o_crc_val          = r_valid & (r_wtype == WT_CRC);
  assign o_row_cnt          = r_row;
  assign o_col_cnt          = r_col;

endmodule

// File: tb/tb_param_frame_mapper.sv
// Directed bench for param_frame_mapper on a 2x4 frame geometry.
// A second instance runs in fill mode on the same stimulus.
module tb_param_frame_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] pyld;
  logic       pvalid;
  logic       line_rdy;
  logic       tran_rdy;
  logic       retrans;
  logic       corrupt;

  logic       req, valid_o, fas_o, fill_o, crc_o;
  logic [7:0] data_o;
  logic       row_o;
  logic [1:0] col_o;

  logic       f_req, f_valid, f_fas, f_fill, f_crc;
  logic [7:0] f_data;
  logic       f_row;
  logic [1:0] f_col;

  always #5 clk = ~clk;

  param_frame_mapper #(
    .DATA_W(8), .ROWS(2), .COLS(4), .FAS_LEN(2),
    .FAS_PATTERN(32'hF628_F628), .FILL_MODE(1'b0),
    .FILL_WORD(8'hAA), .CRC_POLY(8'h07), .CRC_INIT(8'h00)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_pyld_data(pyld), .i_pyld_data_valid(pvalid),
    .o_pyld_data_req(req), .o_frame_data(data_o),
    .o_frame_data_valid(valid_o), .o_frame_data_fas(fas_o),
    .o_fill_ins(fill_o), .i_line_fifo_ready(line_rdy),
    .i_tran_rec_fifo_ready(tran_rdy),
    .i_line_retrans_req(retrans), .i_corrupt_en(corrupt),
    .o_crc_val(crc_o), .o_row_cnt(row_o), .o_col_cnt(col_o)
  );

  param_frame_mapper #(
    .DATA_W(8), .ROWS(2), .COLS(4), .FAS_LEN(2),
    .FAS_PATTERN(32'hF628_F628), .FILL_MODE(1'b1),
    .FILL_WORD(8'hAA), .CRC_POLY(8'h07), .CRC_INIT(8'h00)
  ) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_pyld_data(pyld), .i_pyld_data_valid(pvalid),
    .o_pyld_data_req(f_req), .o_frame_data(f_data),
    .o_frame_data_valid(f_valid), .o_frame_data_fas(f_fas),
    .o_fill_ins(f_fill), .i_line_fifo_ready(line_rdy),
    .i_tran_rec_fifo_ready(tran_rdy),
    .i_line_retrans_req(retrans), .i_corrupt_en(corrupt),
    .o_crc_val(f_crc), .o_row_cnt(f_row), .o_col_cnt(f_col)
  );

  typedef struct {
    logic [7:0] d;
    logic       fas;
    logic       fill;
    logic       crc;
    int         cyc;
  } rec_t;

  rec_t qm[$];
  rec_t qf[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nxfer = 0;
  bit   pmode = 1'b0;

  function automatic logic [7:0] pat(input int n);
    return pmode ? 8'(32'h10 + n) : 8'h00;
  endfunction

  function automatic logic [7:0] crc8(input logic [7:0] c,
                                      input logic [7:0] d);
    logic [7:0] v;
    logic       fb;
    v = c;
    for (int i = 7; i >= 0; i--) begin
      fb = v[7] ^ d[i];
      v  = {v[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return v;
  endfunction

  task automatic tick;
    logic x;
    rec_t r;
    @(negedge clk);
    x = req & pvalid;
    if (valid_o && line_rdy && tran_rdy) begin
      r.d = data_o; r.fas = fas_o; r.fill = fill_o;
      r.crc = crc_o; r.cyc = cyc;
      qm.push_back(r);
    end
    if (f_valid && line_rdy && tran_rdy) begin
      r.d = f_data; r.fas = f_fas; r.fill = f_fill;
      r.crc = f_crc; r.cyc = cyc;
      qf.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (x) begin
      nxfer++;
      pyld = pat(nxfer);
    end
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    en       = 1'b0;
    pvalid   = 1'b0;
    line_rdy = 1'b1;
    tran_rdy = 1'b1;
    retrans  = 1'b0;
    corrupt  = 1'b0;
    nxfer    = 0;
    pyld     = pat(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    qm.delete();
    qf.delete();
  endtask

  task automatic test_reset;
    pmode = 1'b0;
    do_reset();
    en = 1'b1; pvalid = 1'b1;
    repeat (5) tick();
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_valid got=%b want=1", valid_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({valid_o, fas_o, fill_o, crc_o, req} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {valid_o, fas_o, fill_o, crc_o, req});
    end
    total++;
    if ({data_o, row_o, col_o} !== 11'h0) begin
      bad++;
      $display("FAIL reset_data_cnt got=%h want=000",
               {data_o, row_o, col_o});
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({valid_o, req, row_o, col_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=00000",
               {valid_o, req, row_o, col_o});
    end
  endtask

  task automatic test_basic;
    int         c0;
    logic [7:0] ed;
    logic       ef, ec;
    pmode = 1'b0;
    do_reset();
    c0 = cyc;
    en = 1'b1; pvalid = 1'b1;
    for (int k = 0; k < 40 && qm.size() < 9; k++) tick();
    total++;
    if (qm.size() < 9) begin
      bad++;
      $display("FAIL basic_count got=%0d want=9", qm.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        ed = (k == 0 || k == 8) ? 8'hF6
           : (k == 1) ? 8'h28 : 8'h00;
        ef = (k < 2 || k == 8);
        ec = (k == 7);
        total++;
        if ({qm[k].d, qm[k].fas, qm[k].fill, qm[k].crc}
            !== {ed, ef, 1'b0, ec}) begin
          bad++;
          $display("FAIL basic_word%0d got=%h/%b%b%b want=%h/%b0%b",
                   k, qm[k].d, qm[k].fas, qm[k].fill,
                   qm[k].crc, ed, ef, ec);
        end
      end
      total++;
      if (qm[0].cyc !== c0 + 2) begin
        bad++;
        $display("FAIL basic_latency got=%0d want=%0d",
                 qm[0].cyc - c0, 2);
      end
      total++;
      if (qm[8].cyc !== qm[7].cyc + 1) begin
        bad++;
        $display("FAIL basic_nogap got=%0d want=1",
                 qm[8].cyc - qm[7].cyc);
      end
    end
  endtask

  task automatic test_corrupt;
    logic [7:0] ed;
    pmode = 1'b0;
    do_reset();
    corrupt = 1'b1;
    en = 1'b1; pvalid = 1'b1;
    for (int k = 0; k < 40 && qm.size() < 8; k++) tick();
    total++;
    if (qm.size() < 8) begin
      bad++;
      $display("FAIL corrupt_count got=%0d want=8", qm.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ed = (k == 0) ? 8'hF6 : (k == 1) ? 8'h28
           : (k == 7) ? 8'h01 : 8'h00;
        total++;
        if ({qm[k].d, qm[k].crc} !== {ed, k == 7}) begin
          bad++;
          $display("FAIL corrupt_word%0d got=%h/%b want=%h/%b",
                   k, qm[k].d, qm[k].crc, ed, k == 7);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] g, ed;
    pmode = 1'b1;
    do_reset();
    en = 1'b1; pvalid = 1'b1;
    for (int k = 0; k < 30 && nxfer < 2; k++) tick();
    pvalid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++;
      if ({req, row_o, col_o} !== {1'b1, 1'b1, 2'd0}
          || nxfer !== 2) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b%b%0d x%0d want=110 x2",
                 s, req, row_o, col_o, nxfer);
      end
    end
    total++;
    if (qm.size() !== 4) begin
      bad++;
      $display("FAIL stall_lines got=%0d want=4", qm.size());
    end
    pvalid = 1'b1;
    for (int k = 0; k < 40 && qm.size() < 8; k++) tick();
    g = 8'h00;
    for (int i = 0; i < 5; i++) g = crc8(g, 8'(8'h10 + i));
    total++;
    if (qm.size() < 8) begin
      bad++;
      $display("FAIL stall_count got=%0d want=8", qm.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ed = (k == 0) ? 8'hF6 : (k == 1) ? 8'h28
           : (k == 7) ? g : 8'(8'h0E + k);
        total++;
        if (qm[k].d !== ed) begin
          bad++;
          $display("FAIL stall_word%0d got=%h want=%h",
                   k, qm[k].d, ed);
        end
      end
    end
  endtask

  task automatic test_fill;
    logic [7:0] g, ed;
    logic       efl;
    pmode = 1'b0;
    do_reset();
    pvalid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 40 && qf.size() < 8; k++) tick();
    g = 8'h00;
    for (int i = 0; i < 5; i++) g = crc8(g, 8'hAA);
    total++;
    if (qf.size() < 8) begin
      bad++;
      $display("FAIL fill_count got=%0d want=8", qf.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ed  = (k == 0) ? 8'hF6 : (k == 1) ? 8'h28
            : (k == 7) ? g : 8'hAA;
        efl = (k >= 2 && k <= 6);
        total++;
        if ({qf[k].d, qf[k].fill, qf[k].crc}
            !== {ed, efl, k == 7}) begin
          bad++;
          $display("FAIL fill_word%0d got=%h/%b%b want=%h/%b%b",
                   k, qf[k].d, qf[k].fill, qf[k].crc,
                   ed, efl, k == 7);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] g, ed;
    bit         seen;
    pmode = 1'b1;
    do_reset();
    en = 1'b1; pvalid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = valid_o && !fas_o && !crc_o;
    end
    tran_rdy = 1'b0;
    #1;
    total++;
    if (!seen || data_o !== 8'h10) begin
      bad++;
      $display("FAIL bp_first got=%h seen=%b want=10", data_o, seen);
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      total++;
      if ({data_o, valid_o, fas_o, req} !== {8'h10, 3'b100}
          || nxfer !== 1) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h/%b%b%b x%0d want=10/100 x1",
                 s, data_o, valid_o, fas_o, req, nxfer);
      end
    end
    tran_rdy = 1'b1;
    for (int k = 0; k < 40 && qm.size() < 8; k++) tick();
    g = 8'h00;
    for (int i = 0; i < 5; i++) g = crc8(g, 8'(8'h10 + i));
    total++;
    if (qm.size() < 8) begin
      bad++;
      $display("FAIL bp_count got=%0d want=8", qm.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ed = (k == 0) ? 8'hF6 : (k == 1) ? 8'h28
           : (k == 7) ? g : 8'(8'h0E + k);
        total++;
        if (qm[k].d !== ed) begin
          bad++;
          $display("FAIL bp_word%0d got=%h want=%h",
                   k, qm[k].d, ed);
        end
      end
    end
  endtask

  task automatic test_retrans;
    logic [7:0] g, ed;
    pmode = 1'b1;
    do_reset();
    en = 1'b1; pvalid = 1'b1;
    for (int k = 0; k < 30 && nxfer < 2; k++) tick();
    line_rdy = 1'b0;
    tick();
    retrans = 1'b1;
    #1;
    total++;
    if ({req, valid_o, data_o} !== {2'b01, 8'h11}) begin
      bad++;
      $display("FAIL rt_pending got=%b%b/%h want=01/11",
               req, valid_o, data_o);
    end
    tick();
    total++;
    if ({valid_o, row_o, col_o} !== 4'b0 || nxfer !== 2) begin
      bad++;
      $display("FAIL rt_drop got=%b%b%0d x%0d want=000 x2",
               valid_o, row_o, col_o, nxfer);
    end
    total++;
    if (qm.size() !== 3) begin
      bad++;
      $display("FAIL rt_prelines got=%0d want=3", qm.size());
    end
    retrans = 1'b0;
    line_rdy = 1'b1;
    qm.delete();
    tick();
    total++;
    if ({data_o, fas_o, row_o, col_o} !== {8'hF6, 2'b10, 2'd1}) begin
      bad++;
      $display("FAIL rt_restart got=%h/%b%b%0d want=F6/101",
               data_o, fas_o, row_o, col_o);
    end
    en = 1'b0;
    for (int k = 0; k < 40 && qm.size() < 8; k++) tick();
    g = 8'h00;
    for (int i = 0; i < 5; i++) g = crc8(g, 8'(8'h12 + i));
    total++;
    if (qm.size() < 8) begin
      bad++;
      $display("FAIL rt_count got=%0d want=8", qm.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ed = (k == 0) ? 8'hF6 : (k == 1) ? 8'h28
           : (k == 7) ? g : 8'(8'h10 + k);
        total++;
        if (qm[k].d !== ed) begin
          bad++;
          $display("FAIL rt_word%0d got=%h want=%h",
                   k, qm[k].d, ed);
        end
      end
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      total++;
      if ({valid_o, req, row_o, col_o} !== 5'b0) begin
        bad++;
        $display("FAIL rt_idle%0d got=%b want=00000",
                 s, {valid_o, req, row_o, col_o});
      end
    end
    total++;
    if (qm.size() !== 8) begin
      bad++;
      $display("FAIL rt_postlines got=%0d want=8", qm.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_stall();
    test_fill();
    test_backpressure();
    test_retrans();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
